// File: rtl/ras_resolver_if.sv
// Handshake bundle between IF-side RAS, EX jump resolution and the
// RAS prediction checker.
interface ras_resolver_if;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic        ext_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ras_clear;
  logic        recovering;
  logic [5:0]  q_count;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [31:0] drop_cnt;

  modport master (
    output pred_valid, pred_pc, pred_target,
    output res_valid, res_pc, res_target,
    output ext_flush,
    input  redirect_valid, redirect_pc, ras_clear,
    input  recovering, q_count,
    input  hit_cnt, miss_cnt, drop_cnt
  );

  modport slave (
    input  pred_valid, pred_pc, pred_target,
    input  res_valid, res_pc, res_target,
    input  ext_flush,
    output redirect_valid, redirect_pc, ras_clear,
    output recovering, q_count,
    output hit_cnt, miss_cnt, drop_cnt
  );
endinterface

// File: rtl/ras_resolver.sv
// EX-stage checker for RAS predictions: in-order queue of predicted
// returns, compare on resolve, redirect + RAS clear on a wrong target.
module ras_resolver #(
  parameter int DEPTH       = 8,
  parameter int RECOVER_CYC = 2
) (
  input logic          CLK,
  input logic          RESET,
  ras_resolver_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (RECOVER_CYC < 2) ? 1 : $clog2(RECOVER_CYC);
  localparam logic [5:0] FULL = 6'(DEPTH);

  typedef enum logic {
    IDLE,
    RECOVER
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  state_t        state;
  ent_t          mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [5:0]    cnt;
  logic [RW-1:0] rec_cnt;

  logic        redir_q;
  logic [31:0] redir_pc_q;
  logic        clear_q;
  logic        recov_q;
  logic [31:0] hit_q;
  logic [31:0] miss_q;
  logic [31:0] drop_q;

  ent_t head_ent;
  logic empty;
  logic full;
  logic match;
  logic hit;
  logic miss;
  logic push;
  logic drop;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (&v) ? v : v + 32'd1;
  endfunction

  always_comb begin
    head_ent = mem[head];
    empty    = (cnt == 6'd0);
    full     = (cnt == FULL);
    match    = bus.res_valid && !empty &&
               (head_ent.pc == bus.res_pc);
    hit      = match &&
               (head_ent.tgt == bus.res_target);
    miss     = match && !hit;
    // a pop frees the slot the same cycle, so a full queue still accepts
    push     = bus.pred_valid && (state == IDLE) &&
               (!full || hit) && !miss;
    drop     = bus.pred_valid && !push;
  end

  always_ff @(posedge CLK) begin
    if (RESET && push && !bus.ext_flush) begin
      mem[tail] <= '{pc: bus.pred_pc, tgt: bus.pred_target};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      rec_cnt    <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      clear_q    <= 1'b0;
      recov_q    <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
      drop_q     <= '0;
    end else begin
      redir_q <= 1'b0;
      clear_q <= 1'b0;
      if (bus.ext_flush) begin
        state   <= IDLE;
        recov_q <= 1'b0;
        rec_cnt <= '0;
        head    <= '0;
        tail    <= '0;
        cnt     <= '0;
      end else if (miss) begin
        redir_q    <= 1'b1;
        clear_q    <= 1'b1;
        redir_pc_q <= bus.res_target;
        state      <= RECOVER;
        recov_q    <= 1'b1;
        rec_cnt    <= RW'(RECOVER_CYC - 1);
        head       <= '0;
        tail       <= '0;
        cnt        <= '0;
        miss_q     <= sat_inc(miss_q);
        if (drop) begin
          drop_q <= sat_inc(drop_q);
        end
      end else begin
        if (push) begin
          tail <= tail + AW'(1);
        end
        if (hit) begin
          head  <= head + AW'(1);
          hit_q <= sat_inc(hit_q);
        end
        if (drop) begin
          drop_q <= sat_inc(drop_q);
        end
        unique case (1'b1)
          (push && !hit): cnt <= cnt + 6'd1;
          (hit && !push): cnt <= cnt - 6'd1;
          default:        cnt <= cnt;
        endcase
        if (state == RECOVER) begin
          if (rec_cnt == '0) begin
            state   <= IDLE;
            recov_q <= 1'b0;
          end else begin
            rec_cnt <= rec_cnt - RW'(1);
          end
        end
      end
    end
  end

  assign bus.redirect_valid = redir_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.ras_clear      = clear_q;
  assign bus.recovering     = recov_q;
  assign bus.q_count        = cnt;
  assign bus.hit_cnt        = hit_q;
  assign bus.miss_cnt       = miss_q;
  assign bus.drop_cnt       = drop_q;

endmodule

// File: tb/tb_ras_resolver.sv
// Directed bench for ras_resolver: hits, misses, overflow, flush,
// unpredicted jr and reset during recovery.
module tb_ras_resolver;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  ras_resolver_if bus ();

  ras_resolver #(
    .DEPTH      (8),
    .RECOVER_CYC(2)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.pred_valid  = 1'b0;
    bus.pred_pc     = '0;
    bus.pred_target = '0;
    bus.res_valid   = 1'b0;
    bus.res_pc      = '0;
    bus.res_target  = '0;
    bus.ext_flush   = 1'b0;
  endtask

  task automatic push_in(
    input logic [31:0] pc,
    input logic [31:0] tgt
  );
    bus.pred_valid  = 1'b1;
    bus.pred_pc     = pc;
    bus.pred_target = tgt;
  endtask

  task automatic res_in(
    input logic [31:0] pc,
    input logic [31:0] tgt
  );
    bus.res_valid  = 1'b1;
    bus.res_pc     = pc;
    bus.res_target = tgt;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle_in();
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_q", 32'(bus.q_count), 0);
    chk("rst_hit", bus.hit_cnt, 0);
    chk("rst_miss", bus.miss_cnt, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    chk("rst_redir", 32'(bus.redirect_valid), 0);
    chk("rst_clr", 32'(bus.ras_clear), 0);
    chk("rst_rec", 32'(bus.recovering), 0);
    chk("rst_rpc", bus.redirect_pc, 0);
    rst_n = 1'b1;

    // hit
    push_in(32'h100, 32'h208);
    cyc();
    chk("t1_q1", 32'(bus.q_count), 1);
    res_in(32'h100, 32'h208);
    cyc();
    chk("t1_hit", bus.hit_cnt, 1);
    chk("t1_q0", 32'(bus.q_count), 0);
    chk("t1_redir", 32'(bus.redirect_valid), 0);

    // miss, then push inside recovery window
    push_in(32'h100, 32'h208);
    cyc();
    res_in(32'h100, 32'h30C);
    cyc();
    chk("t2_redir", 32'(bus.redirect_valid), 1);
    chk("t2_clr", 32'(bus.ras_clear), 1);
    chk("t2_rpc", bus.redirect_pc, 32'h30C);
    chk("t2_miss", bus.miss_cnt, 1);
    chk("t2_rec1", 32'(bus.recovering), 1);
    chk("t2_q", 32'(bus.q_count), 0);
    push_in(32'h120, 32'h124);
    cyc();
    chk("t2_redir2", 32'(bus.redirect_valid), 0);
    chk("t2_clr2", 32'(bus.ras_clear), 0);
    chk("t2_rec2", 32'(bus.recovering), 1);
    chk("t4_drop", bus.drop_cnt, 1);
    chk("t4_q", 32'(bus.q_count), 0);
    cyc();
    chk("t2_rec3", 32'(bus.recovering), 0);
    chk("t2_hit", bus.hit_cnt, 1);

    // overflow, then push+pop while full
    for (int i = 0; i < 9; i++) begin
      push_in(32'h500 + 32'(i * 4), 32'h600 + 32'(i * 4));
      cyc();
    end
    chk("t3_qfull", 32'(bus.q_count), 8);
    chk("t3_drop", bus.drop_cnt, 2);
    push_in(32'h700, 32'h800);
    res_in(32'h500, 32'h600);
    cyc();
    chk("t3_q8", 32'(bus.q_count), 8);
    chk("t3_hit", bus.hit_cnt, 2);

    // unpredicted jr with non-matching head
    res_in(32'h400, 32'h404);
    cyc();
    chk("t5_q", 32'(bus.q_count), 8);
    chk("t5_hit", bus.hit_cnt, 2);
    chk("t5_miss", bus.miss_cnt, 1);
    chk("t5_redir", 32'(bus.redirect_valid), 0);

    // flush beats a same-cycle push and matching resolve
    bus.ext_flush = 1'b1;
    push_in(32'h900, 32'h904);
    res_in(32'h504, 32'h604);
    cyc();
    chk("t4_fq", 32'(bus.q_count), 0);
    chk("t4_fhit", bus.hit_cnt, 2);
    chk("t4_fdrop", bus.drop_cnt, 2);
    chk("t4_fredir", 32'(bus.redirect_valid), 0);
    for (int i = 0; i < 3; i++) begin
      push_in(32'hA00 + 32'(i * 4), 32'hB00);
      cyc();
    end
    chk("t4_q3", 32'(bus.q_count), 3);
    bus.ext_flush = 1'b1;
    cyc();
    chk("t4_q0", 32'(bus.q_count), 0);
    chk("t4_redir", 32'(bus.redirect_valid), 0);
    chk("t4_miss", bus.miss_cnt, 1);
    res_in(32'h400, 32'h404);
    cyc();
    chk("t5_eq", 32'(bus.q_count), 0);
    chk("t5_emiss", bus.miss_cnt, 1);
    chk("t5_ehit", bus.hit_cnt, 2);

    // push discarded by same-cycle mismatch
    push_in(32'h100, 32'h208);
    cyc();
    push_in(32'h900, 32'h904);
    res_in(32'h100, 32'h999);
    cyc();
    chk("pm_miss", bus.miss_cnt, 2);
    chk("pm_drop", bus.drop_cnt, 3);
    chk("pm_q", 32'(bus.q_count), 0);
    chk("pm_rpc", bus.redirect_pc, 32'h999);
    cyc();
    cyc();
    chk("pm_rec", 32'(bus.recovering), 0);

    // reset while redirect pending / in recovery
    push_in(32'h100, 32'h208);
    cyc();
    res_in(32'h100, 32'h30C);
    cyc();
    chk("t6_pre", 32'(bus.redirect_valid), 1);
    rst_n = 1'b0;
    cyc();
    chk("t6_redir", 32'(bus.redirect_valid), 0);
    chk("t6_rec", 32'(bus.recovering), 0);
    chk("t6_miss", bus.miss_cnt, 0);
    chk("t6_rpc", bus.redirect_pc, 0);
    rst_n = 1'b1;
    cyc();
    chk("t6_redir2", 32'(bus.redirect_valid), 0);
    chk("t6_rec2", 32'(bus.recovering), 0);

    // reset in the same cycle as a mismatch
    push_in(32'h100, 32'h208);
    cyc();
    res_in(32'h100, 32'h30C);
    rst_n = 1'b0;
    cyc();
    chk("t6b_redir", 32'(bus.redirect_valid), 0);
    chk("t6b_miss", bus.miss_cnt, 0);
    chk("t6b_q", 32'(bus.q_count), 0);
    chk("t6b_rec", 32'(bus.recovering), 0);
    rst_n = 1'b1;
    cyc();
    chk("t6b_redir2", 32'(bus.redirect_valid), 0);
    chk("t6b_clr2", 32'(bus.ras_clear), 0);
    chk("t6b_rec2", 32'(bus.recovering), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
